// File: rtl/sobel_pkg.sv
// Shared encodings for the Sobel edge stream: gradient mode codes and the
// frame-level control states.
package sobel_pkg;

  localparam logic [1:0] MODE_LEGACY  = 2'd0;
  localparam logic [1:0] MODE_SUM_ABS = 2'd1;
  localparam logic [1:0] MODE_ABS_X   = 2'd2;
  localparam logic [1:0] MODE_ABS_Y   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel: window pixels plus mode/threshold in,
// one PIX_W edge magnitude out. The centre pixel carries zero weight.
module sobel_kernel
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] t_l,
  input  logic [PIX_W-1:0] t_c,
  input  logic [PIX_W-1:0] t_r,
  input  logic [PIX_W-1:0] m_l,
  input  logic [PIX_W-1:0] m_r,
  input  logic [PIX_W-1:0] b_l,
  input  logic [PIX_W-1:0] b_c,
  input  logic [PIX_W-1:0] b_r,
  input  logic [1:0]       mode,
  input  logic             thresh_en,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] result
);

  localparam int GW = PIX_W + 3;
  localparam int SW = PIX_W + 4;
  localparam logic [PIX_W-1:0] MAX_V = '1;

  function automatic logic signed [GW-1:0] zext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Halve with truncation toward zero: bias negative values by one first.
  function automatic logic signed [SW-1:0] half_trunc(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] t;
    t = v + $signed({{(SW-1){1'b0}}, v[SW-1]});
    return t >>> 1;
  endfunction

  function automatic logic [PIX_W-1:0] clamp_u(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] max_s;
    max_s = $signed({{(SW-PIX_W){1'b0}}, MAX_V});
    if (v < 0)
      return '0;
    else if (v > max_s)
      return MAX_V;
    else
      return v[PIX_W-1:0];
  endfunction

  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic signed [SW-1:0] gx_w;
  logic signed [SW-1:0] gy_w;
  logic signed [SW-1:0] ax;
  logic signed [SW-1:0] ay;
  logic [PIX_W-1:0]     mode_res;

  always_comb begin
    gx   = (zext(t_l) + (zext(m_l) <<< 1) + zext(b_l))
         - (zext(t_r) + (zext(m_r) <<< 1) + zext(b_r));
    gy   = (zext(t_l) + (zext(t_c) <<< 1) + zext(t_r))
         - (zext(b_l) + (zext(b_c) <<< 1) + zext(b_r));
    gx_w = $signed({gx[GW-1], gx});
    gy_w = $signed({gy[GW-1], gy});
    ax   = gx_w[SW-1] ? -gx_w : gx_w;
    ay   = gy_w[SW-1] ? -gy_w : gy_w;

    mode_res = '0;
    case (mode)
      MODE_LEGACY:  mode_res = clamp_u(half_trunc(gx_w + gy_w));
      MODE_SUM_ABS: mode_res = clamp_u(ax + ay);
      MODE_ABS_X:   mode_res = clamp_u(ax);
      MODE_ABS_Y:   mode_res = clamp_u(ay);
      default:      mode_res = '0;
    endcase

    result = mode_res;
    if (thresh_en)
      result = (mode_res >= thresh) ? MAX_V : '0;
  end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, one edge value per
// pixel out in raster order, with a (IMG_W+1)-cycle end-of-frame flush.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic [1:0]       mode,
  input  logic             thresh_en,
  input  logic [PIX_W-1:0] thresh,
  output logic             busy,
  output logic             valid,
  output logic [PIX_W-1:0] edge_out,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 1);

  state_t state_q, state_d;

  logic [CW-1:0] in_col;
  logic [RW-1:0] in_row;
  logic [CW-1:0] out_col;
  logic [RW-1:0] out_row;
  logic [FW-1:0] flush_cnt;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic [PIX_W-1:0] t_a, t_b, m_a, m_b, b_a, b_b;

  logic [1:0]       cfg_mode;
  logic             cfg_ten;
  logic [PIX_W-1:0] cfg_thresh;

  logic             accept_p0, last_in, emit_run, emit_flush, emit_p0;
  logic             border_p0, out_last_p0, flush_end;
  logic [PIX_W-1:0] kres_p0;

  logic             vld_p1, done_p1;
  logic [PIX_W-1:0] edge_p1;

  // Stage p0: accept, window update and kernel evaluation
  always_comb begin
    lb0_rd      = lb0[in_col];
    lb1_rd      = lb1[in_col];
    accept_p0   = pix_valid && (state_q != FLUSH);
    last_in     = (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));
    // Output k needs input k+IMG_W+1, so emission starts at row 1, column 1.
    emit_run    = accept_p0 && ((in_row > RW'(1)) ||
                                ((in_row == RW'(1)) && (in_col != '0)));
    emit_flush  = (state_q == FLUSH);
    emit_p0     = emit_run || emit_flush;
    border_p0   = (out_row == '0) || (out_row == RW'(IMG_H - 1)) ||
                  (out_col == '0) || (out_col == CW'(IMG_W - 1));
    out_last_p0 = (out_row == RW'(IMG_H - 1)) && (out_col == CW'(IMG_W - 1));
    flush_end   = (flush_cnt == FW'(IMG_W));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_p0) state_d = RUN;
      RUN:     if (accept_p0 && last_in) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
    .t_l       (t_a),
    .t_c       (t_b),
    .t_r       (lb1_rd),
    .m_l       (m_a),
    .m_r       (lb0_rd),
    .b_l       (b_a),
    .b_c       (b_b),
    .b_r       (pix_data),
    .mode      (cfg_mode),
    .thresh_en (cfg_ten),
    .thresh    (cfg_thresh),
    .result    (kres_p0)
  );

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      lb1[in_col] <= lb0_rd;
      lb0[in_col] <= pix_data;
      t_a <= t_b;
      t_b <= lb1_rd;
      m_a <= m_b;
      m_b <= lb0_rd;
      b_a <= b_b;
      b_b <= pix_data;
      if (state_q == IDLE) begin
        cfg_mode   <= mode;
        cfg_ten    <= thresh_en;
        cfg_thresh <= thresh;
      end
    end
  end

  // Stage p1: registered output, counters and control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_col    <= '0;
      in_row    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      flush_cnt <= '0;
      vld_p1    <= 1'b0;
      done_p1   <= 1'b0;
      edge_p1   <= '0;
    end else begin
      state_q <= state_d;

      if (accept_p0) begin
        if (in_col == CW'(IMG_W - 1)) begin
          in_col <= '0;
          in_row <= last_in ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      if (emit_p0) begin
        if (out_col == CW'(IMG_W - 1)) begin
          out_col <= '0;
          out_row <= out_last_p0 ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
        // Flush outputs all fall on the last two rows, which are border.
        edge_p1 <= (border_p0 || emit_flush) ? '0 : kres_p0;
      end

      flush_cnt <= emit_flush ? flush_cnt + 1'b1 : '0;
      vld_p1    <= emit_p0;
      done_p1   <= emit_p0 && out_last_p0;
    end
  end

  assign busy       = (state_q == FLUSH);
  assign valid      = vld_p1;
  assign edge_out   = edge_p1;
  assign frame_done = done_p1;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream: a reference model fills a scoreboard
// per frame, and a negedge monitor pops and compares every output.
module tb_sobel_edge_stream;

  localparam int W = 32;
  localparam int H = 32;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'd0;
  logic [1:0] mode = 2'd0;
  logic       thresh_en = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic       busy, valid, frame_done;
  logic [7:0] edge_out;

  int         img [N];
  int         exp_q [$];
  int         tests = 0;
  int         fails = 0;
  int         out_idx = 0;
  int         done_cnt = 0;
  int         acc = 0;
  logic       pend = 1'b0;
  logic       acc_edge;
  logic [7:0] last_edge = 8'd0;

  always #5 clk = ~clk;

  sobel_edge_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .mode       (mode),
    .thresh_en  (thresh_en),
    .thresh     (thresh),
    .busy       (busy),
    .valid      (valid),
    .edge_out   (edge_out),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int px(int r, int c);
    return img[r * W + c];
  endfunction

  function automatic int model(int r, int c, int md, int ten, int th);
    int gx, gy, v, ax, ay;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    gx = px(r-1, c-1) + 2 * px(r, c-1) + px(r+1, c-1)
       - px(r-1, c+1) - 2 * px(r, c+1) - px(r+1, c+1);
    gy = px(r-1, c-1) + 2 * px(r-1, c) + px(r-1, c+1)
       - px(r+1, c-1) - 2 * px(r+1, c) - px(r+1, c+1);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      0:       v = (gx + gy) / 2;
      1:       v = ax + ay;
      2:       v = ax;
      default: v = ay;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    if (ten != 0) v = (v >= th) ? 255 : 0;
    return v;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       img[i] = 77;
        1:       img[i] = ((i % W) >= 16) ? 200 : 0;
        2:       img[i] = ((i / W) < 16) ? 40 : 0;
        default: img[i] = $urandom_range(0, 255);
      endcase
    end
  endtask

  task automatic push_expected(input int md, input int ten, input int th);
    for (int i = 0; i < N; i++) exp_q.push_back(model(i / W, i % W, md, ten, th));
  endtask

  task automatic drive_pixels(input int n, input int gap, input int chg, input int md, input int ten);
    for (int i = 0; i < n; i++) begin
      if (gap != 0) begin
        while ($urandom_range(0, 2) == 0) begin
          pix_valid = 1'b0;
          pix_data  = 8'($urandom_range(0, 255));
          @(posedge clk); #1;
        end
      end
      if (chg != 0 && i == n / 2) begin
        mode      = 2'(md ^ 3);
        thresh_en = (ten == 0);
        thresh    = 8'($urandom_range(0, 255));
      end
      pix_valid = 1'b1;
      pix_data  = img[i][7:0];
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input int md, input int ten, input int th, input int gap, input int chg);
    int bcnt;
    mode      = 2'(md);
    thresh_en = (ten != 0);
    thresh    = 8'(th);
    push_expected(md, ten, th);
    drive_pixels(N, gap, chg, md, ten);
    // Offer junk pixels through the flush when gaps are enabled; all must drop.
    bcnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      pix_valid = (gap != 0);
      pix_data  = 8'($urandom_range(0, 255));
      bcnt++;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("busy_cycles", bcnt, W + 1);
  endtask

  task automatic wait_done(input int target);
    @(negedge clk);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    check("frame_done_count", done_cnt, target);
    check("queue_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    int e;
    if (rst) begin
      last_edge = 8'd0;
      out_idx   = 0;
      acc       = 0;
      pend      = 1'b0;
    end else begin
      acc_edge = pend;
      if (pend) acc = (acc == N) ? 1 : acc + 1;
      if (valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("edge", edge_out, e);
        check("done_pos", frame_done, (out_idx == N - 1));
        if (out_idx < N - W - 1) check("latency", acc_edge ? acc : -1, out_idx + W + 2);
        if (out_idx == N - 1) begin
          out_idx = 0;
          done_cnt++;
        end else begin
          out_idx++;
        end
        last_edge = edge_out;
      end else begin
        check("edge_hold", edge_out, last_edge);
        check("done_idle", frame_done, 0);
      end
      pend = pix_valid && !busy;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_edge", edge_out, 0);
    check("rst_done", frame_done, 0);

    fill(0); send_frame(1, 0, 0, 0, 0);   wait_done(1);
    fill(1); send_frame(2, 0, 0, 0, 0);   wait_done(2);
    send_frame(0, 0, 0, 0, 0);            wait_done(3);
    fill(2); send_frame(3, 0, 0, 0, 0);   wait_done(4);
    send_frame(0, 0, 0, 0, 0);            wait_done(5);
    send_frame(3, 1, 100, 0, 0);          wait_done(6);
    send_frame(3, 1, 161, 0, 0);          wait_done(7);
    fill(3); send_frame(1, 0, 0, 0, 0);   wait_done(8);
    send_frame(1, 0, 0, 1, 0);            wait_done(9);
    send_frame(0, 0, 0, 1, 1);            wait_done(10);

    // Abort a frame after 100 pixels, then run a clean one.
    fill(1);
    mode = 2'd2; thresh_en = 1'b0; thresh = 8'd0;
    push_expected(2, 0, 0);
    drive_pixels(100, 0, 0, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    check("abort_edge", edge_out, 0);
    fill(2); send_frame(3, 0, 0, 0, 1);   wait_done(11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Parametrised streaming 3x3 Sobel edge detector, the next generation of the fixed 32x32 8-bit edge block.
- Accepts one frame of pixels in raster order and emits exactly IMG_W*IMG_H edge values in raster order.
- Unlike the fixed block, it has no per-row stall: input pauses only for the end-of-frame flush.
- Adds selectable gradient modes, a binary threshold and input gaps through pix_valid. It sits between the pixel source and the frame output writer.

Parameters:
- IMG_W, 32, pixels per row (>=3)
- IMG_H, 32, rows per frame (>=3)
- PIX_W, 8, bits per pixel and per edge output

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- pix_valid  in  1  pix_data is offered this cycle
- pix_data  in  PIX_W  unsigned input pixel, raster order
- mode  in  2  0 = legacy (gx+gy)/2 clamp; 1 = |gx|+|gy|; 2 = |gx|; 3 = |gy|
- thresh_en  in  1  binarise the output
- thresh  in  PIX_W  threshold value
- busy  out  1  high means input is not accepted
- valid  out  1  edge_out holds a result this cycle
- edge_out  out  PIX_W  edge magnitude
- frame_done  out  1  one-cycle pulse together with the last output of a frame

Behaviour:
- Reset: one clock is used, and reset is synchronous and active-high. On reset, busy=0, valid=0, edge_out=0, frame_done=0, counters clear and state goes to IDLE. Line buffers need no clearing.
- Reset mid-frame aborts the frame; the next accepted pixel is pixel 0 of a new frame.
- Accept rule: a pixel is accepted when pix_valid=1 and busy=0. pix_valid while busy=1 is ignored and the pixel is dropped.
- States:
  - IDLE -> RUN on the first accepted pixel. mode, thresh_en and thresh are latched on that cycle and held for the whole frame.
  - RUN -> FLUSH on acceptance of the pixel at linear index IMG_W*IMG_H-1.
  - FLUSH lasts exactly IMG_W+1 cycles with busy=1, then returns to IDLE with busy=0.
- Storage: two line buffers of IMG_W x PIX_W plus a 3x3 window of registers. Row/column counters track the window centre.
- Output timing, with linear index k = r*IMG_W + c:
  - Output k is presented, valid=1, on the cycle after input index k+IMG_W+1 is accepted.
  - Outputs whose k+IMG_W+1 >= IMG_W*IMG_H are emitted one per cycle during FLUSH.
  - Input gaps therefore propagate as output gaps. valid is otherwise 0.
  - edge_out holds its last value while valid=0.
- Border: any output with r=0, r=IMG_H-1, c=0 or c=IMG_W-1 is 0, regardless of mode and threshold.
- Gradients, with window rows top/mid/bot and columns L/C/R:
  - gx = (tL + 2mL + bL) - (tR + 2mR + bR)
  - gy = (tL + 2tC + tR) - (bL + 2bC + bR)
  - Both are signed, PIX_W+3 bits. Pixels are zero-extended before use.
- Mode results:
  - Mode 0: (gx+gy)/2, truncated toward zero, then clamped to [0, 2^PIX_W-1].
  - Mode 1: |gx|+|gy|, saturated to 2^PIX_W-1.
  - Modes 2 and 3: |gx| or |gy| respectively, saturated to 2^PIX_W-1.
- Threshold: when thresh_en=1, the result becomes 2^PIX_W-1 if the mode result >= thresh, else 0. Border outputs stay 0.
- frame_done asserts on the same cycle as valid for output index IMG_W*IMG_H-1.
- Back-to-back frames: the next frame's first pixel may be accepted on the first cycle busy=0 after FLUSH.

Decomposition:
- Package sobel_pkg holds the mode encoding constants (MODE_LEGACY, MODE_SUM_ABS, MODE_ABS_X, MODE_ABS_Y) and the state enum (IDLE, RUN, FLUSH).
- One sub-module, sobel_kernel: purely combinational 3x3 window plus mode/thresh -> PIX_W result. It is reused by the later colour variant.

Test Plan:
- Uniform frame of 77s, mode 1 -> 1024 outputs all 0; frame_done once; busy high exactly 33 cycles after the last input.
- Vertical step (columns 0-15 = 0, columns 16-31 = 200), mode 2 -> columns 15 and 16 of interior rows = 255, all else 0. Same image in mode 0 -> all 0 (gx = -800 clamps).
- Horizontal step (rows 0-15 = 40, rows 16-31 = 0), mode 3 -> interior rows 15 and 16 = 160. Mode 0 -> 80 on those rows, 0 elsewhere.
- Same horizontal step, mode 3, thresh_en=1, thresh=100 -> 255 on rows 15/16 interior, 0 elsewhere. thresh=161 -> all 0.
- Random image with random pix_valid gaps -> output sequence identical to the gapless run. Pixels offered during busy are dropped, and the output count stays 1024.
- rst asserted for 1 cycle after 100 accepted pixels, then a full step frame -> next cycle valid=0, busy=0; the following frame output matches the golden model. mode changed mid-frame has no effect until the next frame.
